mem_dbus_ctrl: RTL

- Memory-stage data-bus controller, directly upstream of the MEM/WB pipeline register.
- Turns load/store/LL/SC ops from EX/MEM into req/ack data-bus transactions and stalls the pipeline while a transaction is outstanding.
- Aligns load data and produces the write-back fields (GPR write, LLbit write) consumed by MEM/WB.
- Non-memory instructions pass through combinationally with no stall.

---
 rtl/mem_dbus_ctrl_if.sv | 14 +
 rtl/mem_dbus_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_dbus_ctrl_if.sv
// Request/acknowledge data bus between the memory-stage controller and data memory.
// Big-endian byte lanes; the master holds the request fields stable until ack.
interface mem_dbus_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, sel, wdata, input rdata, ack);
    modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_dbus_ctrl.sv
// Memory-stage data-bus controller: issues load/store/LL/SC on the data bus, stalls the
// pipeline while a transaction is outstanding and builds the MEM/WB write-back fields.
//
// state | meaning
// IDLE  | ops pass through; aligned memory ops issue a bus request
// BUSY  | request outstanding; waits for ack or timeout
// DONE  | write-back fields come from the result registers
// DRAIN | flushed while busy; finish the bus cycle, discard the data
module mem_dbus_ctrl #(
    parameter int ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [4:0]  mem_waddr_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        llbit_i,
    output logic [4:0]  mem_waddr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_LLbit_we_o,
    output logic        mem_LLbit_value_o,
    output logic        stallreq,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    mem_dbus_ctrl_if.master dbus
);
    localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                           OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8,
                           OP_LL = 4'd9, OP_SC = 4'd10;
    localparam int            CW   = $clog2(ACK_TIMEOUT + 2);
    localparam logic [CW-1:0] TLIM = CW'(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;
    state_t state, state_nxt;

    logic          is_load, is_store, is_byte, is_half, misalign, is_mem;
    logic [3:0]    sel_c;
    logic [31:0]   wdata_c;
    logic          issue, ack_v, timeout, pending;
    logic [CW-1:0] cnt, cnt_inc;
    logic [3:0]    r_op;
    logic [1:0]    r_off;
    logic [4:0]    r_waddr;
    logic          r_we;
    logic          res_we, res_ll_we, res_ll_val;
    logic [31:0]   res_wdata;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_val;
    logic          unused_stall;

    // Only the MEM-stage bit of the stall vector matters here.
    assign unused_stall = ^{stall[5], stall[3:0]};

    always_comb begin
        is_load  = (mem_op >= OP_LB && mem_op <= OP_LW) || mem_op == OP_LL;
        is_store = (mem_op >= OP_SB && mem_op <= OP_SW) || mem_op == OP_SC;
        is_byte  = mem_op == OP_LB || mem_op == OP_LBU || mem_op == OP_SB;
        is_half  = mem_op == OP_LH || mem_op == OP_LHU || mem_op == OP_SH;
        is_mem   = is_load || is_store;
        if (is_byte) begin
            sel_c   = 4'b1000 >> mem_addr[1:0];
            wdata_c = {4{mem_reg2[7:0]}};
        end else if (is_half) begin
            sel_c   = mem_addr[1] ? 4'b0011 : 4'b1100;
            wdata_c = {2{mem_reg2[15:0]}};
        end else begin
            sel_c   = 4'b1111;
            wdata_c = mem_reg2;
        end
        misalign = (is_half && mem_addr[0]) ||
                   (!is_byte && !is_half && mem_addr[1:0] != 2'b00);
    end

    always_comb begin
        case (r_off)
            2'd0:    rd_byte = dbus.rdata[31:24];
            2'd1:    rd_byte = dbus.rdata[23:16];
            2'd2:    rd_byte = dbus.rdata[15:8];
            default: rd_byte = dbus.rdata[7:0];
        endcase
        rd_half = r_off[1] ? dbus.rdata[15:0] : dbus.rdata[31:16];
        case (r_op)
            OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_val = {24'h0, rd_byte};
            OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_val = {16'h0, rd_half};
            default: load_val = dbus.rdata;
        endcase
    end

    assign cnt_inc = cnt + CW'(1);
    assign ack_v   = dbus.ack && dbus.req;
    assign timeout = (ACK_TIMEOUT > 0) && (cnt_inc == TLIM);
    assign pending = state == BUSY || state == DRAIN;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        issue             = 1'b0;
        stallreq          = 1'b0;
        exc_adel          = 1'b0;
        exc_ades          = 1'b0;
        mem_waddr_o       = mem_waddr_i;
        mem_we_o          = mem_we_i;
        mem_wdata_o       = mem_wdata_i;
        mem_LLbit_we_o    = 1'b0;
        mem_LLbit_value_o = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem && misalign) begin
                    exc_adel = is_load;
                    exc_ades = is_store;
                    mem_we_o = 1'b0;
                end else if (mem_op == OP_SC && !llbit_i) begin
                    mem_we_o    = 1'b1;
                    mem_wdata_o = 32'h0;
                end else if (is_mem) begin
                    mem_we_o = 1'b0;
                    if (!flush) begin
                        stallreq  = 1'b1;
                        issue     = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                stallreq = 1'b1;
                mem_we_o = 1'b0;
                if (ack_v || timeout) state_nxt = flush ? IDLE : DONE;
                else if (flush)       state_nxt = DRAIN;
            end
            DRAIN: begin
                stallreq = 1'b1;
                mem_we_o = 1'b0;
                if (ack_v || timeout) state_nxt = IDLE;
            end
            default: begin
                mem_waddr_o       = r_waddr;
                mem_we_o          = res_we && !flush;
                mem_wdata_o       = res_wdata;
                mem_LLbit_we_o    = res_ll_we && !flush;
                mem_LLbit_value_o = res_ll_val;
                if (flush || !stall[4]) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbus.req   <= 1'b0;
            dbus.we    <= 1'b0;
            dbus.addr  <= 32'h0;
            dbus.sel   <= 4'h0;
            dbus.wdata <= 32'h0;
            cnt        <= '0;
            bus_err    <= 1'b0;
            r_op       <= 4'h0;
            r_off      <= 2'b00;
            r_waddr    <= 5'h0;
            r_we       <= 1'b0;
            res_we     <= 1'b0;
            res_wdata  <= 32'h0;
            res_ll_we  <= 1'b0;
            res_ll_val <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            if (issue) begin
                dbus.req   <= 1'b1;
                dbus.we    <= is_store;
                dbus.addr  <= {mem_addr[31:2], 2'b00};
                dbus.sel   <= sel_c;
                dbus.wdata <= wdata_c;
                cnt        <= '0;
                r_op       <= mem_op;
                r_off      <= mem_addr[1:0];
                r_waddr    <= mem_waddr_i;
                r_we       <= mem_we_i;
            end else if (pending) begin
                if (ack_v) begin
                    dbus.req <= 1'b0;
                end else if (timeout) begin
                    dbus.req <= 1'b0;
                    bus_err  <= 1'b1;
                end else begin
                    cnt <= cnt_inc;
                end
            end
            // Result registers only matter when BUSY goes on to DONE.
            if (state == BUSY && ack_v) begin
                res_ll_val <= r_op == OP_LL;
                res_ll_we  <= r_op == OP_LL || r_op == OP_SC;
                if (r_op == OP_SC) begin
                    res_we    <= 1'b1;
                    res_wdata <= 32'h1;
                end else begin
                    res_we    <= r_we && !(r_op >= OP_SB && r_op <= OP_SW);
                    res_wdata <= load_val;
                end
            end else if (state == BUSY && timeout) begin
                res_we    <= 1'b0;
                res_ll_we <= 1'b0;
            end
        end
    end
endmodule
